// File: rtl/seg_scan_mux.sv
// seg_scan_mux - time-multiplexed scanner for the 7-segment bank.
// Each slot selects one digit for the downstream decoder and drives the
// matching anode and decimal point. It also provides:
//   - a guard window at the start of every slot,
//   - leading-zero blanking,
//   - per-digit blink.
// Slot decisions (digit value, lit flag, dp request) are captured once per
// slot and held. Input changes mid-slot therefore never disturb the display.
module seg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYC    = 50000,
  parameter int GUARD_CYC   = 500,
  parameter int BLINK_SLOTS = 2000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ca,
  input  logic [4*DIGITS-1:0]         digits,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        lzb,
  input  logic [DIGITS-1:0]           blink_mask,
  output logic [3:0]                  bin,
  output logic [DIGITS-1:0]           an,
  output logic                        dp,
  output logic [$clog2(DIGITS)-1:0]   idx
);

  localparam int IDXW = $clog2(DIGITS);
  localparam int PW   = $clog2(SLOT_CYC);
  localparam int FW   = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(SLOT_CYC - 1);
  localparam logic [PW-1:0]   GUARD_END  = PW'(GUARD_CYC);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);
  localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_SLOTS - 1);

  // One-hot anode pattern for a scan index, in active-high sense.
  function automatic logic [DIGITS-1:0] onehot(input logic [IDXW-1:0] sel);
    logic [DIGITS-1:0] v;
    v = {{(DIGITS-1){1'b0}}, 1'b1};
    return v << sel;
  endfunction

  // Scan state.
  logic [PW-1:0]     presc_q,  presc_d;
  logic [IDXW-1:0]   idx_q,    idx_d;
  logic [FW-1:0]     frame_q,  frame_d;
  logic              phase_q,  phase_d;

  // Per-slot captured decisions.
  logic [3:0]        bin_q,    bin_d;
  logic              lit_q,    lit_d;
  logic              dpreq_q,  dpreq_d;

  // Active-high output intent, converted to the selected polarity at the pins.
  logic [DIGITS-1:0] an_act_q, an_act_d;
  logic              dp_act_q, dp_act_d;
  logic              ca_q;

  // Combinational helpers.
  logic              slot_end_s;
  logic              scan_wrap_s;
  logic              slot_start_s;
  logic              upper_zero_s;
  logic              blanked_s;
  logic              lz_blank_s;
  logic              lit_now_s;
  logic              pol_s;

  // Slot/frame boundary detection from the current counter values.
  always_comb begin
    slot_end_s   = (presc_q == PRESC_LAST);
    scan_wrap_s  = slot_end_s && (idx_q == IDX_LAST);
    slot_start_s = (presc_q == {PW{1'b0}});
  end

  // Detect that the current digit and every more-significant digit are zero.
  always_comb begin
    upper_zero_s = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((IDXW'(k) >= idx_q) && (digits[4*k +: 4] != 4'h0)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
  end

  // Lit decision for the slot that is starting now.
  // phase_q already holds the post-toggle phase when a blink toggle coincides
  // with the slot boundary, because the toggle happened on the wrap edge.
  always_comb begin
    blanked_s  = blink_mask[idx_q] && phase_q;
    lz_blank_s = lzb && (idx_q != {IDXW{1'b0}}) && upper_zero_s;
    lit_now_s  = !blanked_s && !lz_blank_s;
  end

  // Next-state logic for the prescaler, scan index, frame counter and blink phase.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (slot_end_s) begin
      presc_d = {PW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDXW{1'b0}};
      end else begin
        idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
    if (scan_wrap_s) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = {FW{1'b0}};
        phase_d = !phase_q;
      end else begin
        frame_d = frame_q + {{(FW-1){1'b0}}, 1'b1};
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Capture digit, lit flag and dp request once at slot start; hold otherwise.
  always_comb begin
    bin_d   = bin_q;
    lit_d   = lit_q;
    dpreq_d = dpreq_q;
    if (slot_start_s) begin
      bin_d   = digits[{idx_q, 2'b00} +: 4];
      lit_d   = lit_now_s;
      dpreq_d = dp_in[idx_q];
    end else begin
      bin_d   = bin_q;
      lit_d   = lit_q;
      dpreq_d = dpreq_q;
    end
  end

  // Next-cycle anode/dp intent: dark during the guard window, else only the
  // current digit, and only when lit. The active window never contains a
  // slot boundary, so idx_q is the index of the next cycle too.
  always_comb begin
    an_act_d = {DIGITS{1'b0}};
    dp_act_d = 1'b0;
    if ((presc_d >= GUARD_END) && lit_d) begin
      an_act_d = onehot(idx_q);
      dp_act_d = dpreq_d;
    end else begin
      an_act_d = {DIGITS{1'b0}};
      dp_act_d = 1'b0;
    end
  end

  // Main state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= {PW{1'b0}};
      idx_q    <= {IDXW{1'b0}};
      frame_q  <= {FW{1'b0}};
      phase_q  <= 1'b0;
      bin_q    <= 4'h0;
      lit_q    <= 1'b0;
      dpreq_q  <= 1'b0;
      an_act_q <= {DIGITS{1'b0}};
      dp_act_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      bin_q    <= bin_d;
      lit_q    <= lit_d;
      dpreq_q  <= dpreq_d;
      an_act_q <= an_act_d;
      dp_act_q <= dp_act_d;
    end
  end

  // Registered polarity so a ca change reaches an/dp on the next edge.
  // It has no reset value because the inactive level itself depends on ca.
  always_ff @(posedge clk) begin
    ca_q <= ca;
  end

  // Output polarity: while reset is held, follow ca directly so the pins are
  // inactive at the requested polarity even before the first clock edge.
  always_comb begin
    if (reset) begin
      pol_s = ca;
    end else begin
      pol_s = ca_q;
    end
  end

  // Drive pins at the selected polarity; bin is never inverted here.
  always_comb begin
    if (pol_s) begin
      an = ~an_act_q;
      dp = ~dp_act_q;
    end else begin
      an = an_act_q;
      dp = dp_act_q;
    end
    bin = bin_q;
    idx = idx_q;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux.
// The reference model derives slot, index, frame and blink phase from the
// cycle count since reset release, using plain arithmetic.
module tb_seg_scan_mux;

  localparam int DIGITS      = 4;
  localparam int SLOT_CYC    = 4;
  localparam int GUARD_CYC   = 1;
  localparam int BLINK_SLOTS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ca;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  blink_mask;
  logic [3:0]  bin;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  idx;

  seg_scan_mux #(
    .DIGITS(DIGITS), .SLOT_CYC(SLOT_CYC),
    .GUARD_CYC(GUARD_CYC), .BLINK_SLOTS(BLINK_SLOTS)
  ) dut (
    .clk(clk), .reset(reset), .ca(ca), .digits(digits), .dp_in(dp_in),
    .lzb(lzb), .blink_mask(blink_mask), .bin(bin), .an(an), .dp(dp), .idx(idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  // Model state: inputs as seen at the current slot's start edge.
  logic        ca_last;
  logic [15:0] s_digits;
  logic [3:0]  s_dp;
  logic [3:0]  s_blink;
  logic        s_lzb;
  logic [3:0]  bin_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  // Random digit word, biased toward zero nibbles to exercise blanking.
  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    v = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Compare the current cycle against the model, optionally perturb inputs,
  // capture the slot snapshot, and advance to the next negedge.
  task automatic step(input bit rnd);
    int   slot, p, ix, frame;
    bit   phase, lit;
    logic [3:0] act, exp_an;
    logic dpa, exp_dp;
    slot  = t / SLOT_CYC;
    p     = t % SLOT_CYC;
    ix    = slot % DIGITS;
    frame = slot / DIGITS;
    phase = ((frame / BLINK_SLOTS) % 2) == 1;
    lit   = !(s_blink[ix] && phase) && !(s_lzb && ix != 0 && (s_digits >> (4*ix)) == 0);
    if (p < GUARD_CYC || !lit) begin
      act = 4'b0000;
      dpa = 1'b0;
    end else begin
      act = 4'(1 << ix);
      dpa = s_dp[ix];
    end
    exp_an = ca_last ? ~act : act;
    exp_dp = ca_last ? ~dpa : dpa;
    chk("an", an, exp_an);
    chk("dp", dp, exp_dp);
    chk("bin", bin, bin_exp);
    chk("idx", idx, ix);
    chk("onehot", ($countones(an ^ {4{ca_last}}) <= 1), 1);
    if (rnd) begin
      if ($urandom_range(0, 3) == 0) digits = rand_digits();
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) ca = ~ca;
    end
    if (p == 0) begin
      s_digits = digits;
      s_dp     = dp_in;
      s_blink  = blink_mask;
      s_lzb    = lzb;
      bin_exp  = digits[4*ix +: 4];
    end
    ca_last = ca;
    @(negedge clk);
    t++;
  endtask

  task automatic release_reset();
    reset   = 1'b0;
    t       = 0;
    bin_exp = 4'h0;
    ca_last = ca;
  endtask

  initial begin
    reset = 1'b1; ca = 1'b1; digits = 16'h1234; dp_in = 4'b0000;
    lzb = 1'b0; blink_mask = 4'b0000;
    s_digits = 16'h0; s_dp = 4'h0; s_blink = 4'h0; s_lzb = 1'b0;
    bin_exp = 4'h0; ca_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_bin", bin, 4'h0);
    chk("rst_idx", idx, 2'd0);
    release_reset();

    // Basic scan, common anode.
    step(1'b0);
    chk("t1_an", an, 4'b1110);  chk("t1_bin", bin, 4'h4);
    repeat (4) step(1'b0);
    chk("t5_an", an, 4'b1101);  chk("t5_bin", bin, 4'h3);
    repeat (4) step(1'b0);
    chk("t9_an", an, 4'b1011);  chk("t9_bin", bin, 4'h2);
    repeat (4) step(1'b0);
    chk("t13_an", an, 4'b0111); chk("t13_bin", bin, 4'h1);
    repeat (3) step(1'b0);
    chk("wrap_idx", idx, 2'd0); chk("wrap_an", an, 4'b1111);

    // Active-high polarity.
    ca = 1'b0;
    repeat (16) step(1'b0);

    // Leading-zero blanking.
    ca = 1'b1; digits = 16'h0070; lzb = 1'b1;
    repeat (32) step(1'b0);
    digits = 16'h0000;
    repeat (32) step(1'b0);

    // Blink on digits 0-1, dp follows.
    digits = 16'h1234; lzb = 1'b0; blink_mask = 4'b0011; dp_in = 4'b1111;
    repeat (96) step(1'b0);

    // dp on slot 2 only, then reset in the third cycle of slot 2.
    blink_mask = 4'b0000; dp_in = 4'b0100;
    while ((t % 16) != 10) step(1'b0);
    chk("pre_rst_an", an, 4'b1011);
    chk("pre_rst_dp", dp, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_bin", bin, 4'h0);
    chk("mid_rst_idx", idx, 2'd0);
    repeat (2) @(negedge clk);
    release_reset();
    step(1'b0);
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_idx", idx, 2'd0);

    // Randomized run.
    repeat (3000) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed display scanner for the clock's 7-segment bank.
- Sits directly upstream of the binary-to-7-segment decoder. Each slot it picks one 4-bit digit from a packed digit word and presents it on `bin` for the decoder. At the same time it drives the matching anode and decimal point.
- Provides anti-ghosting guard time, leading-zero blanking and per-digit blink for time-set mode.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SLOT_CYC, 50000, clk cycles per digit slot (≥ GUARD_CYC+1).
- GUARD_CYC, 500, cycles at the start of each slot with all anodes inactive (≥1).
- BLINK_SLOTS, 2000, full scan frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ca  in  1  polarity select, same meaning as at the decoder: 1 = common anode (an/dp active-low), 0 = active-high.
- digits  in  4*DIGITS  packed digit values, digit k at [4k+3:4k]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal-point request per digit.
- lzb  in  1  leading-zero blanking enable.
- blink_mask  in  DIGITS  digits to blink.
- bin  out  4  current digit value to the decoder.
- an  out  DIGITS  anode enables, one-hot active when lit.
- dp  out  1  decimal point for the current digit.
- idx  out  clog2(DIGITS)  current scan index.

Behaviour:
- Reset (async assert, sync-effective release):
  - prescaler=0, idx=0, frame counter=0, blink phase=0, bin=0.
  - an all inactive (ca ? all 1s : all 0s); dp inactive.
- Prescaler counts 0..SLOT_CYC-1 and wraps. At the wrap, idx advances by 1; after DIGITS-1 it wraps to 0.
- Frame counter increments when idx wraps to 0. At count BLINK_SLOTS-1 it clears and blink phase toggles.
- Slot start (prescaler==0, registered):
  - bin <= digits[idx], sampled for the new idx.
  - lit flag and dp value are computed and held for the whole slot.
  - Input changes mid-slot are not seen until the next slot.
- Guard interval (prescaler < GUARD_CYC): an all inactive, dp inactive.
- Active interval (prescaler ≥ GUARD_CYC): only an[idx] is active, and only if lit. dp = dp_in[idx] at active polarity, and only if lit.
- Lit rules (all must pass):
  - Blink: digit not blanked, where blanked = blink_mask[idx] && phase==1.
  - Leading-zero blanking: if lzb=1, a digit is unlit when it and every higher digit are 0.
  - Digit 0 is never blanked by leading-zero blanking; it can still be blanked by blink.
- Simultaneous blink-toggle and slot boundary: the lit flag uses the post-toggle phase.
- ca change takes effect on the next clock edge for an/dp. No restart of the scan.
- Reset mid-slot: outputs go inactive immediately (async); scanning restarts at idx 0 after release.
- At most one anode is ever active in any cycle.
- The decoder applies `ca` to segments itself. This block never inverts `bin`.

Test Plan:
1. Use DIGITS=4, SLOT_CYC=4, GUARD_CYC=1, BLINK_SLOTS=2, ca=1, digits=16'h1234, lzb=0. Required response:
   - an = 1111 for 1 cycle, then 1110 for 3 cycles with bin=4.
   - Then bin=3 with an=1101, bin=2 with an=1011, bin=1 with an=0111.
   - idx then wraps to 0.
2. Same settings, ca=0. Required response: an patterns are inverted (0001, 0010, …); the guard cycle shows 0000.
3. digits=16'h0070, lzb=1. Required response:
   - Digits 3 and 2 are never lit.
   - Digit 1 lit with bin=7; digit 0 lit with bin=0.
   - With digits=16'h0000, only digit 0 is lit.
4. blink_mask=4'b0011, BLINK_SLOTS=2. Required response:
   - Digits 0–1 are lit for 2 frames, dark for 2 frames, and so on.
   - Digits 2–3 are always lit; dp behaves the same way.
5. dp_in=4'b0100, ca=1. Required response: dp=0 only during the active cycles of slot idx=2; dp=1 during guard cycles and all other slots.
6. Assert reset at the third cycle of the idx=2 slot. Required response:
   - an=1111, dp=1, bin=0 in the same cycle, without waiting for a clock.
   - After release, the first lit slot is idx=0 after 1 guard cycle.
